// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - CORDIC constants, arctangent table and mode type
package cordic_pkg;

    typedef enum logic {
        MODE_ROT = 1'b0,
        MODE_VEC = 1'b1
    } cordic_mode_e;

    localparam int ATAN_ENTRIES = 24;

    // atan(2^-s) in Q.16, rounded to nearest
    localparam longint ATAN_Q16 [0:ATAN_ENTRIES-1] = '{
        51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
        256, 128, 64, 32, 16, 8, 4, 2,
        1, 0, 0, 0, 0, 0, 0, 0
    };

    localparam longint PI_Q16   = 205887;
    localparam longint PI_2_Q16 = (PI_Q16 + 1) / 2;
    localparam longint K_Q16    = 39797;

    function automatic longint scale_q16(input longint v, input int frac);
        if (frac >= 16)
            return v <<< (frac - 16);
        return v >>> (16 - frac);
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// rtl/cordic_stage.sv - one registered CORDIC micro-rotation with fixed shift and angle
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int                    W     = 26,
    parameter int                    SHIFT = 0,
    parameter logic signed [W-1:0]   ATAN  = '0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_vld,
    input  cordic_mode_e        i_mode,
    input  logic signed [W-1:0] i_x,
    input  logic signed [W-1:0] i_y,
    input  logic signed [W-1:0] i_z,
    output logic                o_vld,
    output cordic_mode_e        o_mode,
    output logic signed [W-1:0] o_x,
    output logic signed [W-1:0] o_y,
    output logic signed [W-1:0] o_z
);

    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;
    logic                d_pos;

    // d = +1 drives z toward zero (rotation) or y toward zero (vectoring)
    always_comb begin
        x_sh  = i_x >>> SHIFT;
        y_sh  = i_y >>> SHIFT;
        d_pos = (i_mode == MODE_ROT) ? !i_z[W-1] : i_y[W-1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_vld  <= 1'b0;
            o_mode <= MODE_ROT;
        end else if (i_en) begin
            o_vld  <= i_vld;
            o_mode <= i_mode;
            if (d_pos) begin
                o_x <= i_x - y_sh;
                o_y <= i_y + x_sh;
                o_z <= i_z - ATAN;
            end else begin
                o_x <= i_x + y_sh;
                o_y <= i_y - x_sh;
                o_z <= i_z + ATAN;
            end
        end
    end

endmodule

// File: rtl/cordic_engine.sv
// rtl/cordic_engine.sv - pipelined CORDIC for sin/cos rotation and magnitude/atan2 vectoring
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int  QINT  = 8,
    parameter int  QFRAC = 16,
    parameter int  ITER  = 16,
    localparam int QBITS = QINT + QFRAC
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic             i_mode,
    input  logic [QBITS-1:0] i_x,
    input  logic [QBITS-1:0] i_y,
    input  logic [QBITS-1:0] i_z,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [QBITS-1:0] o_x,
    output logic [QBITS-1:0] o_y,
    output logic [QBITS-1:0] o_z,
    output logic             o_mode
);

    localparam int W  = QBITS + 2;
    localparam int PW = W + QFRAC + 2;

    localparam logic signed [W-1:0]     PI_2_W = W'(scale_q16(PI_2_Q16, QFRAC));
    localparam logic signed [QFRAC+1:0] K_S    = (QFRAC+2)'(scale_q16(K_Q16, QFRAC));
    localparam logic signed [PW-1:0]    HALF   = PW'(longint'(1) <<< (QFRAC - 1));
    localparam logic signed [PW-1:0]    QMAX   = PW'((longint'(1) <<< (QBITS - 1)) - 1);
    localparam logic signed [PW-1:0]    QMIN   = PW'(-(longint'(1) <<< (QBITS - 1)));

    if (ITER < 4 || ITER > QFRAC || ITER > ATAN_ENTRIES) begin : g_iter_check
        $error("cordic_engine: ITER must lie in 4..QFRAC");
    end

    logic         stall;
    cordic_mode_e in_mode;

    assign stall   = o_vld && !i_rdy;
    assign o_rdy   = !stall;
    assign in_mode = cordic_mode_e'(i_mode);

    // stage 0: quadrant fold so the remaining angle fits the CORDIC range
    logic signed [W-1:0] ex, ey, ez;
    logic signed [W-1:0] p_x, p_y, p_z;

    always_comb begin
        ex  = {{2{i_x[QBITS-1]}}, i_x};
        ey  = {{2{i_y[QBITS-1]}}, i_y};
        ez  = {{2{i_z[QBITS-1]}}, i_z};
        p_x = ex;
        p_y = ey;
        p_z = ez;
        if (in_mode == MODE_ROT) begin
            if (ez > PI_2_W) begin
                p_x = -ey;
                p_y = ex;
                p_z = ez - PI_2_W;
            end else if (ez < -PI_2_W) begin
                p_x = ey;
                p_y = -ex;
                p_z = ez + PI_2_W;
            end
        end else if (ex[W-1]) begin
            if (!ey[W-1]) begin
                p_x = ey;
                p_y = -ex;
                p_z = ez + PI_2_W;
            end else begin
                p_x = -ey;
                p_y = ex;
                p_z = ez - PI_2_W;
            end
        end
    end

    logic                s0_v;
    cordic_mode_e        s0_m;
    logic signed [W-1:0] s0_x, s0_y, s0_z;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s0_v <= 1'b0;
            s0_m <= MODE_ROT;
        end else if (!stall) begin
            s0_v <= i_vld;
            s0_m <= in_mode;
            s0_x <= p_x;
            s0_y <= p_y;
            s0_z <= p_z;
        end
    end

    logic                st_v [1:ITER];
    cordic_mode_e        st_m [1:ITER];
    logic signed [W-1:0] st_x [1:ITER];
    logic signed [W-1:0] st_y [1:ITER];
    logic signed [W-1:0] st_z [1:ITER];

    for (genvar i = 0; i < ITER; i++) begin : g_stage
        logic                in_v;
        cordic_mode_e        in_m;
        logic signed [W-1:0] in_x, in_y, in_z;

        if (i == 0) begin : g_src
            assign in_v = s0_v;
            assign in_m = s0_m;
            assign in_x = s0_x;
            assign in_y = s0_y;
            assign in_z = s0_z;
        end else begin : g_src
            assign in_v = st_v[i];
            assign in_m = st_m[i];
            assign in_x = st_x[i];
            assign in_y = st_y[i];
            assign in_z = st_z[i];
        end

        cordic_stage #(
            .W     (W),
            .SHIFT (i),
            .ATAN  (W'(scale_q16(ATAN_Q16[i], QFRAC)))
        ) u_stage (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_en   (!stall),
            .i_vld  (in_v),
            .i_mode (in_m),
            .i_x    (in_x),
            .i_y    (in_y),
            .i_z    (in_z),
            .o_vld  (st_v[i+1]),
            .o_mode (st_m[i+1]),
            .o_x    (st_x[i+1]),
            .o_y    (st_y[i+1]),
            .o_z    (st_z[i+1])
        );
    end

    function automatic logic [QBITS-1:0] sat(input logic signed [PW-1:0] v);
        if (v > QMAX)
            return QMAX[QBITS-1:0];
        if (v < QMIN)
            return QMIN[QBITS-1:0];
        return v[QBITS-1:0];
    endfunction

    // gain compensation: multiply by K, round half-up, drop QFRAC bits
    logic signed [PW-1:0] prod_x, prod_y, rnd_x, rnd_y;

    always_comb begin
        prod_x = PW'(st_x[ITER]) * PW'(K_S);
        prod_y = PW'(st_y[ITER]) * PW'(K_S);
        rnd_x  = (prod_x + HALF) >>> QFRAC;
        rnd_y  = (prod_y + HALF) >>> QFRAC;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_vld  <= 1'b0;
            o_mode <= 1'b0;
            o_x    <= '0;
            o_y    <= '0;
            o_z    <= '0;
        end else if (!stall) begin
            o_vld  <= st_v[ITER];
            o_mode <= st_m[ITER];
            o_x    <= sat(rnd_x);
            o_y    <= sat(rnd_y);
            o_z    <= sat(PW'(st_z[ITER]));
        end
    end

endmodule

// File: tb/tb_cordic_engine.sv
// tb/tb_cordic_engine.sv - scoreboard bench for cordic_engine
module tb_cordic_engine;

    localparam int  QINT  = 8;
    localparam int  QFRAC = 16;
    localparam int  ITER  = 16;
    localparam int  QBITS = QINT + QFRAC;
    localparam real SCALE = 65536.0;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_vld;
    logic             o_rdy;
    logic             i_mode;
    logic [QBITS-1:0] i_x, i_y, i_z;
    logic             o_vld;
    logic             i_rdy;
    logic [QBITS-1:0] o_x, o_y, o_z;
    logic             o_mode;

    cordic_engine #(.QINT(QINT), .QFRAC(QFRAC), .ITER(ITER)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_vld  (i_vld),
        .o_rdy  (o_rdy),
        .i_mode (i_mode),
        .i_x    (i_x),
        .i_y    (i_y),
        .i_z    (i_z),
        .o_vld  (o_vld),
        .i_rdy  (i_rdy),
        .o_x    (o_x),
        .o_y    (o_y),
        .o_z    (o_z),
        .o_mode (o_mode)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int     id;
        logic   mode;
        longint ex, ey, ez;
        longint tx, ty, tz;
        bit     abs_z;
        bit     chk_lat;
        longint t_in;
    } exp_t;

    exp_t   sb[$];
    exp_t   m_e;
    int     n_checks = 0;
    int     n_errors = 0;
    int     n_sent   = 0;
    int     n_out    = 0;
    longint cyc      = 0;
    bit     rdy_rand = 1'b0;

    task automatic check(input string tag, input longint act, input longint expv, input longint tol);
        longint d;
        n_checks++;
        d = act - expv;
        if (d < 0)
            d = -d;
        if (d > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, act, expv, tol);
        end
    endtask

    function automatic longint sx(input logic [QBITS-1:0] v);
        return longint'($signed(v));
    endfunction

    always @(posedge i_clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge i_clk);
        #1;
        i_rdy = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    always @(negedge i_clk) begin
        if (!i_rst && o_vld === 1'b1 && i_rdy === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0, 0);
            end else begin
                m_e = sb.pop_front();
                n_out++;
                check($sformatf("s%0d_mode", m_e.id), longint'(o_mode), longint'(m_e.mode), 0);
                check($sformatf("s%0d_x", m_e.id), sx(o_x), m_e.ex, m_e.tx);
                check($sformatf("s%0d_y", m_e.id), sx(o_y), m_e.ey, m_e.ty);
                if (m_e.abs_z)
                    check($sformatf("s%0d_absz", m_e.id), (sx(o_z) < 0) ? -sx(o_z) : sx(o_z), m_e.ez, m_e.tz);
                else
                    check($sformatf("s%0d_z", m_e.id), sx(o_z), m_e.ez, m_e.tz);
                if (m_e.chk_lat)
                    check($sformatf("s%0d_latency", m_e.id), cyc - m_e.t_in, ITER + 2, 0);
            end
        end
    end

    task automatic send(input logic mode, input longint x, y, z, ex, ey, ez, tx, ty, tz,
                        input bit abs_z, input bit chk_lat);
        exp_t e;
        int   waited;
        i_vld  = 1'b1;
        i_mode = mode;
        i_x    = QBITS'(x);
        i_y    = QBITS'(y);
        i_z    = QBITS'(z);
        waited = 0;
        @(negedge i_clk);
        while (o_rdy !== 1'b1 && waited < 500) begin
            @(negedge i_clk);
            waited++;
        end
        if (o_rdy !== 1'b1) begin
            check("accept_timeout", 0, 1, 0);
        end else begin
            e.id = n_sent; e.mode = mode;
            e.ex = ex; e.ey = ey; e.ez = ez;
            e.tx = tx; e.ty = ty; e.tz = tz;
            e.abs_z = abs_z; e.chk_lat = chk_lat; e.t_in = cyc;
            sb.push_back(e);
            n_sent++;
        end
        @(posedge i_clk);
        #1;
        i_vld = 1'b0;
    endtask

    task automatic send_rot(input longint x, y, z, input longint tol);
        real th, xr, yr;
        th = real'(z) / SCALE;
        xr = real'(x);
        yr = real'(y);
        send(1'b0, x, y, z, longint'(xr * $cos(th) - yr * $sin(th)),
             longint'(xr * $sin(th) + yr * $cos(th)), 0, tol, tol, tol, 1'b0, 1'b0);
    endtask

    task automatic send_vec(input longint x, y, input longint tol);
        real xr, yr;
        xr = real'(x);
        yr = real'(y);
        send(1'b1, x, y, 0, longint'($sqrt(xr * xr + yr * yr)), 0,
             longint'($atan2(yr, xr) * SCALE), tol, tol, tol, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge i_clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0, 0);
            sb.delete();
        end
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_o_vld"}, longint'(o_vld), 0, 0);
        check({tag, "_o_rdy"}, longint'(o_rdy), 1, 0);
        check({tag, "_o_x"}, longint'(o_x), 0, 0);
        check({tag, "_o_y"}, longint'(o_y), 0, 0);
        check({tag, "_o_z"}, longint'(o_z), 0, 0);
        check({tag, "_o_mode"}, longint'(o_mode), 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint x, y, z;
        int     n0;
        bit     vld_seen;

        i_rst = 1'b1; i_vld = 1'b0; i_mode = 1'b0;
        i_x = '0; i_y = '0; i_z = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_state("por");
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // directed cases with spec-given expectations
        send(1'b0, 'h10000, 0, 'h0C910, 'h0B505, 'h0B505, 0, 4, 4, 8, 1'b0, 1'b1);
        wait_drain(100);
        send(1'b0, 'h10000, 0, 'h3243F, -65536, 0, 0, 4, 4, 8, 1'b0, 1'b1);
        wait_drain(100);
        send(1'b1, 'h30000, 'h40000, 0, 'h50000, 0, 'h0ED63, 4, 16, 4, 1'b0, 1'b1);
        wait_drain(100);
        send(1'b1, -65536, 0, 0, 'h10000, 0, 'h3243F, 4, 8, 4, 1'b1, 1'b1);
        wait_drain(100);

        // mixed-mode back-to-back stream with random backpressure
        rdy_rand = 1'b1;
        n0 = n_out;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                x = longint'(int'($urandom_range(0, 91750))) - 45875;
                y = longint'(int'($urandom_range(0, 91750))) - 45875;
                z = longint'(int'($urandom_range(0, 411773))) - 205887;
                send_rot(x, y, z, 8);
            end else begin
                do begin
                    x = longint'(int'($urandom_range(0, 91750))) - 45875;
                    y = longint'(int'($urandom_range(0, 91750))) - 45875;
                end while (x * x + y * y < 16384 * 16384);
                send_vec(x, y, 8);
            end
        end
        wait_drain(2000);
        rdy_rand = 1'b0;
        check("stream_count", n_out - n0, 40, 0);
        @(posedge i_clk);
        #1;

        // reset with samples in flight, plus a sample offered during reset
        for (int k = 0; k < 10; k++)
            send_rot(longint'(20000 + 1000 * k), 0, longint'(5000 * k), 8);
        i_rst = 1'b1;
        i_vld = 1'b1; i_mode = 1'b1;
        i_x = 24'h020000; i_y = 24'h010000; i_z = '0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_vld = 1'b0;
        sb.delete();
        check_reset_state("midrst");
        vld_seen = 1'b0;
        repeat (25) begin
            @(negedge i_clk);
            vld_seen |= o_vld;
        end
        check("rst_flush_vld", longint'(vld_seen), 0, 0);
        @(posedge i_clk);
        #1;
        send(1'b0, 'h10000, 0, 0, 'h10000, 0, 0, 4, 4, 8, 1'b0, 1'b1);
        wait_drain(100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
